// File: rtl/h80cpu_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : h80cpu_uart_tx
// Brief    : IO-bus mapped 8N1 UART transmitter with a byte FIFO.
// Revision : 1.0
// ============================================================================
module h80cpu_uart_tx #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [2:0]  cmd,
    input  logic        run,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        txd
);

    localparam int c_DIV   = CLK_FREQ / BAUD;
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);

    // bus_cmd_t encoding shared with the rest of the IO bus
    localparam logic [2:0] c_CMD_READ_B  = 3'd1;
    localparam logic [2:0] c_CMD_READ_W  = 3'd2;
    localparam logic [2:0] c_CMD_WRITE_B = 3'd3;
    localparam logic [2:0] c_CMD_WRITE_W = 3'd4;

    localparam logic [15:0] c_ADDR_DATA   = 16'h0000;
    localparam logic [15:0] c_ADDR_STATUS = 16'h0002;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic [1:0]         r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_txd;

    logic               r_done;
    logic [15:0]        r_rd_data;

    logic w_pending;
    logic w_is_write;
    logic w_is_status;
    logic w_full;
    logic w_empty;
    logic w_busy;
    logic w_push;
    logic w_pop;
    logic w_complete;
    logic w_unused;

    assign w_pending   = run ^ r_done;
    assign w_is_write  = ((cmd == c_CMD_WRITE_B) || (cmd == c_CMD_WRITE_W)) && (addr == c_ADDR_DATA);
    assign w_is_status = ((cmd == c_CMD_READ_B) || (cmd == c_CMD_READ_W)) && (addr == c_ADDR_STATUS);
    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_busy      = !w_empty || (r_state != c_ST_IDLE);
    // A data write waits for space; everything else finishes on first sight.
    assign w_push      = w_pending && w_is_write && !w_full;
    assign w_complete  = w_pending && (!w_is_write || !w_full);
    assign w_pop       = (r_state == c_ST_IDLE) && !w_empty;
    assign w_unused    = &{1'b0, wr_data[15:8]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_rd_data <= 16'h0000;
        end else if (w_complete) begin
            r_done <= ~r_done;
            if (w_is_status) begin
                r_rd_data <= {14'b0, w_full, w_busy};
            end else if (!w_is_write) begin
                r_rd_data <= 16'h0000;
            end
        end
    end

    // txd is registered together with the state so it always matches it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_txd   <= 1'b1;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= r_mem[r_rptr];
                        r_txd   <= 1'b0;
                        r_div   <= '0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= c_ST_DATA;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                c_ST_DATA: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                c_ST_STOP: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign txd     = r_txd;
    assign done    = r_done;
    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_h80cpu_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_h80cpu_uart_tx
// Brief    : Self-checking bench: bus-driven pushes, line-level frame decoder.
// Revision : 1.0
// ============================================================================
module tb_h80cpu_uart_tx;

    localparam int CLK_FREQ = 27000000;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 16;
    localparam int c_DIV    = CLK_FREQ / BAUD;

    localparam logic [2:0] c_CMD_READ_B  = 3'd1;
    localparam logic [2:0] c_CMD_READ_W  = 3'd2;
    localparam logic [2:0] c_CMD_WRITE_B = 3'd3;
    localparam logic [2:0] c_CMD_WRITE_W = 3'd4;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] addr    = 16'h0;
    logic [2:0]  cmd     = 3'd0;
    logic        run     = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic [15:0] rd_data;
    logic        done;
    logic        txd;

    h80cpu_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .cmd     (cmd),
        .run     (run),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .done    (done),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         gap_q[$];
    int         frames       = 0;
    int         last_end_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line decoder: a frame is ten windows of c_DIV samples, each window constant.
    bit         mon_active = 1'b0;
    bit         mon_seen   = 1'b0;
    bit         mon_err    = 1'b0;
    int         mon_pos    = 0;
    int         mon_idle   = 0;
    logic [9:0] mon_bits   = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                mon_active = 1'b0;
                mon_seen   = 1'b0;
                mon_idle   = 0;
            end else begin
                if (!mon_active) begin
                    if (txd === 1'b0) begin
                        mon_active = 1'b1;
                        mon_pos    = 0;
                        mon_err    = 1'b0;
                        if (mon_seen) gap_q.push_back(mon_idle);
                    end else begin
                        mon_idle++;
                    end
                end
                if (mon_active) begin
                    if (mon_pos % c_DIV == 0) mon_bits[mon_pos / c_DIV] = txd;
                    else if (txd !== mon_bits[mon_pos / c_DIV]) mon_err = 1'b1;
                    mon_pos++;
                    if (mon_pos == 10 * c_DIV) begin
                        check("frame_shape", {29'b0, mon_err, mon_bits[0], mon_bits[9]}, 32'b001);
                        rx_q.push_back(mon_bits[8:1]);
                        frames++;
                        last_end_cyc = cyc;
                        mon_active   = 1'b0;
                        mon_seen     = 1'b1;
                        mon_idle     = 0;
                    end
                end
            end
        end
    end

    // Issue one request from a negedge and wait for the done toggle.
    task automatic bus_req(input logic [15:0] a, input logic [2:0] c, input logic [15:0] d,
                           input int budget, output logic [15:0] rd, output int lat);
        addr    = a;
        cmd     = c;
        wr_data = d;
        run     = ~run;
        lat     = 0;
        while (done !== run && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (done !== run) check("req_timeout", {31'b0, done}, {31'b0, run});
        rd = rd_data;
    endtask

    task automatic wr_byte(input logic [7:0] b, input int budget, output int lat);
        logic [15:0] rd;
        logic [2:0]  c;
        c = ($urandom_range(0, 1) == 0) ? c_CMD_WRITE_B : c_CMD_WRITE_W;
        bus_req(16'h0000, c, {8'($urandom), b}, budget, rd, lat);
        exp_q.push_back(b);
    endtask

    task automatic rd_status(input string tag, input logic [15:0] exp);
        logic [15:0] rd;
        int          lat;
        bus_req(16'h0002, ($urandom_range(0, 1) == 0) ? c_CMD_READ_B : c_CMD_READ_W, 16'h0, 8, rd, lat);
        check(tag, {16'b0, rd}, {16'b0, exp});
        check({tag, "_lat"}, lat, 1);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (rx_q.size() < n) check("frame_timeout", rx_q.size(), n);
    endtask

    task automatic compare_rx(input string tag);
        int i;
        i = 0;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check($sformatf("%s_byte%0d", tag, i), {24'b0, rx_q.pop_front()}, {24'b0, exp_q.pop_front()});
            i++;
        end
        check({tag, "_leftover"}, rx_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        int          nbad;
        int          base;
        int          lows;
        logic [15:0] a;
        logic [2:0]  c;
        logic [7:0]  msg [3];

        msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h21;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_txd", {31'b0, txd}, 1);
        check("reset_done", {31'b0, done}, 0);
        check("reset_rd_data", {16'b0, rd_data}, 0);

        // Single frame of 'H'
        bus_req(16'h0000, c_CMD_WRITE_B, 16'hA548, 8, rd, lat);
        exp_q.push_back(8'h48);
        check("write_lat", lat, 1);
        wait_frames(1, 12 * c_DIV);
        compare_rx("single");
        repeat (2) @(negedge clk);
        rd_status("status_idle", 16'h0000);

        // Three back-to-back frames; the second push meets the first pop
        gap_q.delete();
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            wr_byte(msg[i], 8, lat);
            if (lat != 1) nbad++;
        end
        check("hi_write_lat", nbad, 0);
        rd_status("status_busy", 16'h0001);
        wait_frames(3, 35 * c_DIV);
        compare_rx("hi");
        check("hi_gap_count", gap_q.size(), 3);
        if (gap_q.size() == 3) begin
            check("hi_gap1", gap_q[1], 1);
            check("hi_gap2", gap_q[2], 1);
        end

        // Fill: one byte in flight plus DEPTH queued, then one more stalls
        repeat (2) @(negedge clk);
        gap_q.delete();
        base = frames;
        nbad = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr_byte(8'($urandom), 8, lat);
            if (lat != 1) nbad++;
        end
        check("fill_write_lat", nbad, 0);
        rd_status("status_full", 16'h0003);
        wr_byte(8'($urandom), 12 * c_DIV, lat);
        check("stall_long", {31'b0, lat > c_DIV}, 1);
        check("stall_after_frame1", frames - base, 1);
        check("stall_release_time", {31'b0, (cyc - last_end_cyc) >= 2 && (cyc - last_end_cyc) <= 4}, 1);
        wait_frames(DEPTH + 2, (DEPTH + 3) * 11 * c_DIV);
        compare_rx("burst");
        nbad = 0;
        for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] != 1) nbad++;
        check("burst_gaps", nbad, 0);
        repeat (3) @(negedge clk);
        rd_status("status_drained", 16'h0000);

        // Unmapped and mismatched requests complete with zero data
        bus_req(16'h0004, c_CMD_READ_W, 16'h0, 8, rd, lat);
        check("read_0004", {16'b0, rd}, 0);
        check("read_0004_lat", lat, 1);
        bus_req(16'h0002, c_CMD_WRITE_W, 16'h0055, 8, rd, lat);
        check("write_status_addr", {16'b0, rd}, 0);
        bus_req(16'h0000, c_CMD_READ_B, 16'h0, 8, rd, lat);
        check("read_data_addr", {16'b0, rd}, 0);

        // Randomised mix of data writes and junk requests
        base = frames;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                wr_byte(8'($urandom), 8, lat);
            end else begin
                do begin
                    a = ($urandom_range(0, 2) == 0) ? 16'(2 * $urandom_range(0, 1)) : 16'($urandom);
                    c = 3'($urandom);
                end while ((a == 16'h0000 && (c == c_CMD_WRITE_B || c == c_CMD_WRITE_W)) ||
                           (a == 16'h0002 && (c == c_CMD_READ_B || c == c_CMD_READ_W)));
                bus_req(a, c, 16'($urandom), 8, rd, lat);
                check($sformatf("junk_%0d_rd", i), {16'b0, rd}, 0);
                check($sformatf("junk_%0d_lat", i), lat, 1);
            end
        end
        wait_frames(exp_q.size(), (exp_q.size() + 1) * 11 * c_DIV);
        compare_rx("random");

        // Reset during data bit 3 with five bytes queued
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) wr_byte(8'($urandom), 8, lat);
        lat = 0;
        while (!(mon_active && mon_pos == 4 * c_DIV + 5) && lat < 12 * c_DIV) begin
            @(negedge clk);
            lat++;
        end
        if (!(mon_active && mon_pos == 4 * c_DIV + 5)) check("bit3_timeout", mon_pos, 4 * c_DIV + 5);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        check("abort_txd", {31'b0, txd}, 1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        base = frames;
        rd_status("status_after_reset", 16'h0000);
        lows = 0;
        repeat (12 * c_DIV) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("no_frames_after_reset", lows, 0);
        check("frame_count_after_reset", frames - base, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
